// File: rtl/race_game_ctrl_if.sv
// Board-side bundle for race_game_ctrl: the button/switch synchroniser drives
// the master side, and the controller serves the slave side.
interface race_game_ctrl_if #(
  parameter int MOVE_W = 4,
  parameter int TOT_W  = 8,
  parameter int DEPTH  = 4
);
  logic                    newGame;
  logic                    enter;
  logic [MOVE_W-1:0]       hMove;
  logic [MOVE_W-1:0]       cMove;
  logic [TOT_W-1:0]        total;
  logic [DEPTH*MOVE_W-1:0] hHist;
  logic [DEPTH*MOVE_W-1:0] cHist;
  logic                    illegal;
  logic                    win;
  logic                    lose;
  logic                    humanTurn;

  modport master (
    output newGame, enter, hMove,
    input  cMove, total, hHist, cHist, illegal, win, lose, humanTurn
  );
  modport slave (
    input  newGame, enter, hMove,
    output cMove, total, hHist, cHist, illegal, win, lose, humanTurn
  );
endinterface

// File: rtl/race_game_ctrl.sv
// Race-to-TARGET game controller: the human and an optimal computer alternately add 1..MAX_MOVE.
// Define GAME_HIST_EN to build the per-player move history shift registers.
module race_game_ctrl #(
  parameter int MOVE_W   = 4,
  parameter int MAX_MOVE = 7,
  parameter int TARGET   = 50,
  parameter int TOT_W    = 8,
  parameter int DEPTH    = 4
) (
  input logic             clock,
  input logic             reset,
  race_game_ctrl_if.slave gif
);
  localparam int SW = ((TOT_W > MOVE_W) ? TOT_W : MOVE_W) + 1;
  localparam int HW = DEPTH * MOVE_W;

  typedef enum logic [2:0] {IDLE, HUMAN_TURN, COMP_TURN, HUMAN_WIN, COMP_WIN} state_e;

  state_e            state_q;
  logic              enter_q;
  logic              illegal_q;
  logic [TOT_W-1:0]  total_q;
  logic [MOVE_W-1:0] cmove_q;

  logic              enter_rise;
  logic              h_legal;
  logic [SW-1:0]     h_sum, c_sum, c_mod;
  logic [MOVE_W-1:0] c_move;

  assign enter_rise = gif.enter & ~enter_q;

  // Sums are one bit wider than the total, so a big move cannot wrap past TARGET.
  assign h_sum   = SW'(total_q) + SW'(gif.hMove);
  assign h_legal = (gif.hMove != '0) && (gif.hMove <= MOVE_W'(MAX_MOVE)) &&
                   (h_sum <= SW'(TARGET));

  // Leave the remainder at a multiple of MAX_MOVE+1. A one-step move is used when
  // that is already the case: the remainder is then at least MAX_MOVE+1.
  assign c_mod  = (SW'(TARGET) - SW'(total_q)) % SW'(MAX_MOVE + 1);
  assign c_move = (c_mod == '0) ? MOVE_W'(1) : MOVE_W'(c_mod);
  assign c_sum  = SW'(total_q) + SW'(c_move);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      enter_q   <= 1'b0;
      illegal_q <= 1'b0;
      total_q   <= '0;
      cmove_q   <= '0;
    end else begin
      enter_q   <= gif.enter;
      illegal_q <= 1'b0;
      if (gif.newGame) begin
        state_q <= HUMAN_TURN;
        total_q <= '0;
        cmove_q <= '0;
      end else begin
        case (state_q)
          HUMAN_TURN:
            if (enter_rise) begin
              if (h_legal) begin
                total_q <= TOT_W'(h_sum);
                state_q <= (h_sum == SW'(TARGET)) ? HUMAN_WIN : COMP_TURN;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          COMP_TURN: begin
            total_q <= TOT_W'(c_sum);
            cmove_q <= c_move;
            state_q <= (c_sum == SW'(TARGET)) ? COMP_WIN : HUMAN_TURN;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_HIST_EN
  logic [HW-1:0] hhist_q, chist_q;
  logic          push_h, push_c;

  assign push_h = !gif.newGame && (state_q == HUMAN_TURN) && enter_rise && h_legal;
  assign push_c = !gif.newGame && (state_q == COMP_TURN);

  always_ff @(posedge clock) begin
    if (reset || gif.newGame) begin
      hhist_q <= '0;
      chist_q <= '0;
    end else begin
      if (push_h) hhist_q <= (hhist_q << MOVE_W) | HW'(gif.hMove);
      if (push_c) chist_q <= (chist_q << MOVE_W) | HW'(c_move);
    end
  end

  assign gif.hHist = hhist_q;
  assign gif.cHist = chist_q;
`else
  assign gif.hHist = '0;
  assign gif.cHist = '0;
`endif

  assign gif.total     = total_q;
  assign gif.cMove     = cmove_q;
  assign gif.illegal   = illegal_q;
  assign gif.win       = (state_q == HUMAN_WIN);
  assign gif.lose      = (state_q == COMP_WIN);
  assign gif.humanTurn = (state_q == HUMAN_TURN);
endmodule
